// File: rtl/mul_pow2_mod_pkg.sv
// Shared constants and types for the a*2^k mod CHAR corrector.
// WORD_SIZE / CHAR are the field parameters shared by the whole datapath.
// char_mult(j) returns j*CHAR (j = 0..3) at the 4r reduction width.
package mul_pow2_mod_pkg;
    localparam int                    WORD_SIZE  = 16;
    localparam logic [WORD_SIZE-1:0]  CHAR       = 16'd65521;  // largest 16-bit prime
    localparam int                    KW_DEFAULT = 10;         // holds 2*WORD_SIZE

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_QUAD = 2'd1,
        ST_DBL  = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    function automatic logic [WORD_SIZE+1:0] char_mult(input int j);
        logic [WORD_SIZE+1:0] m;
        m = {2'b00, CHAR};
        case (j)
            0:       return '0;
            1:       return m;
            2:       return m << 1;
            default: return (m << 1) + m;
        endcase
    endfunction
endpackage

// File: rtl/mul_pow2_mod_if.sv
// Request/response bundle for mul_pow2_mod.
//   master (requester): drives start, a, k; observes ready, busy, done, c.
//   slave  (block)    : the reverse.
interface mul_pow2_mod_if
    import mul_pow2_mod_pkg::*;
#(
    parameter int KW = KW_DEFAULT
);
    logic                 start;
    logic [WORD_SIZE-1:0] a;
    logic [KW-1:0]        k;
    logic                 ready;
    logic                 busy;
    logic                 done;
    logic [WORD_SIZE-1:0] c;

    modport master (output start, a, k, input  ready, busy, done, c);
    modport slave  (input  start, a, k, output ready, busy, done, c);
endinterface

// File: rtl/mul_pow2_mod_mul4_path_unit.sv
// Mul4PathUnit: one candidate of the modular reduction.
//   opnd : shifted working value (4r, or 2r in the doubling step)
//   mult : j*CHAR for this candidate
//   diff : low WORD_SIZE bits of opnd - mult (valid when selected)
//   neg  : 1 when opnd < mult
module mul4_path_unit
    import mul_pow2_mod_pkg::*;
#(
    parameter int W = WORD_SIZE
) (
    input  logic [W+1:0] opnd,
    input  logic [W+1:0] mult,
    output logic [W-1:0] diff,
    output logic         neg
);
    logic [W+2:0] sub;
    logic [1:0]   unused_hi;

    assign sub       = {1'b0, opnd} - {1'b0, mult};
    assign neg       = sub[W+2];
    // A selected candidate is always < CHAR, so the top bits are zero.
    assign diff      = sub[W-1:0];
    assign unused_hi = sub[W+1:W];
endmodule

// File: rtl/mul_pow2_mod.sv
// mul_pow2_mod: computes c = a * 2^k mod CHAR (undoes 2^-k scaling).
// Two doublings per QUAD cycle; an odd k finishes with one DBL cycle.
// Ports: clk, rst (sync, active-high), bus (mul_pow2_mod_if.slave):
//   start/a/k request, ready (IDLE), busy (QUAD/DBL), done pulse, c result.
// Config: define MUL_POW2_ODD_K_EN to honour k[0] (DBL state); otherwise
//   k[0] is ignored and latency is 1 + floor(k/2).
module mul_pow2_mod
    import mul_pow2_mod_pkg::*;
#(
    parameter int KW = KW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    mul_pow2_mod_if.slave   bus
);
    localparam int              W       = WORD_SIZE;
    localparam logic [KW-2:0]   CNT_ONE = 1;

    state_e          state_q, state_d;
    logic [W-1:0]    r_q, r_d;
    logic [W-1:0]    c_q, c_d;
    logic [KW-2:0]   cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
`ifdef MUL_POW2_ODD_K_EN
    logic            odd_q, odd_d;
`else
    logic            unused_k0;
    assign unused_k0 = bus.k[0];
`endif

    // Shared reduction: four candidates opnd - j*CHAR evaluated in parallel.
    logic [W+1:0]          opnd;
    logic [3:0]            neg;
    logic [3:0][W-1:0]     diff;
    logic [W-1:0]          red;

`ifdef MUL_POW2_ODD_K_EN
    // DBL reuses the same units on 2r; j=2,3 are then always negative.
    assign opnd = (state_q == ST_DBL) ? {1'b0, r_q, 1'b0} : {r_q, 2'b00};
`else
    assign opnd = {r_q, 2'b00};
`endif

    for (genvar j = 0; j < 4; j++) begin : g_path
        mul4_path_unit #(.W(W)) u_path (
            .opnd (opnd),
            .mult (char_mult(j)),
            .diff (diff[j]),
            .neg  (neg[j])
        );
    end

    // Candidates shrink with j, so the highest non-negative j wins.
    always_comb begin
        red = diff[0];
        if (!neg[1]) red = diff[1];
        if (!neg[2]) red = diff[2];
        if (!neg[3]) red = diff[3];
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        done_d  = 1'b0;
`ifdef MUL_POW2_ODD_K_EN
        odd_d   = odd_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    r_d   = bus.a;
                    cnt_d = bus.k[KW-1:1];
`ifdef MUL_POW2_ODD_K_EN
                    odd_d = bus.k[0];
`endif
                    if (bus.k[KW-1:1] != '0) begin
                        state_d = ST_QUAD;
`ifdef MUL_POW2_ODD_K_EN
                    end else if (bus.k[0]) begin
                        state_d = ST_DBL;
`endif
                    end else begin
                        state_d = ST_FIN;
                        c_d     = bus.a;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_QUAD: begin
                r_d   = red;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
`ifdef MUL_POW2_ODD_K_EN
                    if (odd_q) begin
                        state_d = ST_DBL;
                    end else begin
                        state_d = ST_FIN;
                        c_d     = red;
                        done_d  = 1'b1;
                    end
`else
                    state_d = ST_FIN;
                    c_d     = red;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef MUL_POW2_ODD_K_EN
            ST_DBL: begin
                r_d     = red;
                state_d = ST_FIN;
                c_d     = red;
                done_d  = 1'b1;
            end
`endif
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d == ST_QUAD) || (state_d == ST_DBL);
    end

    // c and done are loaded on entry to FIN so c is valid while done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            cnt_q   <= '0;
            c_q     <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
`ifdef MUL_POW2_ODD_K_EN
            odd_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
`ifdef MUL_POW2_ODD_K_EN
            odd_q   <= odd_d;
`endif
        end
    end

    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.c     = c_q;
endmodule

// File: tb/tb_mul_pow2_mod.sv
// Directed + random bench for mul_pow2_mod (c = a*2^k mod 65521).
module tb_mul_pow2_mod;
    localparam int          KW   = 10;
    localparam longint      PRIM = 65521;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    mul_pow2_mod_if #(.KW(KW)) bus ();

    mul_pow2_mod #(.KW(KW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: k plain doublings, each reduced mod the prime.
    function automatic longint ref_model(input longint a, input int k);
        longint r;
        int     ke;
`ifdef MUL_POW2_ODD_K_EN
        ke = k;
`else
        ke = k & ~1;
`endif
        r = a;
        for (int i = 0; i < ke; i++) r = (r * 2) % PRIM;
        return r;
    endfunction

    function automatic int ref_lat(input int k);
`ifdef MUL_POW2_ODD_K_EN
        return 1 + k / 2 + (k % 2);
`else
        return 1 + k / 2;
`endif
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, wait for done, check latency/result, then the pulse end.
    task automatic run_op(input int a, input int k, input string tag);
        int n;
        int kv;
        kv        = k;
        bus.start = 1'b1;
        bus.a     = a[15:0];
        bus.k     = kv[KW-1:0];
        step();
        bus.start = 1'b0;
        n = 1;
        while (bus.done !== 1'b1 && n < 2000) begin
            step();
            n++;
        end
        check({tag, " latency"}, n, ref_lat(k));
        check({tag, " c"}, bus.c, ref_model(a, k));
        step();
        check({tag, " done_pulse/ready"}, {bus.done, bus.ready}, 2'b01);
    endtask

    initial begin
        int n;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.k     = '0;

        // Reset state
        step();
        step();
        check("rst ready", bus.ready, 1);
        check("rst busy",  bus.busy,  0);
        check("rst done",  bus.done,  0);
        check("rst c",     bus.c,     0);
        rst = 1'b0;
        step();

        // Directed vectors
        run_op(1, 2, "a1k2");
        check("a1k2 c=4", bus.c, 4);
        run_op(65520, 1, "aMaxk1");
        run_op(5, 0, "a5k0");
        check("a5k0 c=5", bus.c, 5);
        run_op(3, 4, "b2b a3k4");
        check("b2b c=48", bus.c, 48);
        run_op(0, 9, "a0k9");
        run_op(12345, 32, "k2W");
        run_op(65520, 31, "aMaxk31");

        // start during busy must be ignored (a=2,k=6 -> 128 after 4 cycles)
        bus.start = 1'b1;
        bus.a     = 16'd2;
        bus.k     = 10'd6;
        step();
        check("ign busy", bus.busy, 1);
        bus.a = 16'd9;
        bus.k = 10'd2;
        n = 1;
        while (bus.done !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        bus.start = 1'b0;
        check("ign latency", n, 4);
        check("ign c", bus.c, 128);
        step();
        step();
        check("ign no restart", {bus.ready, bus.busy}, 2'b10);

        // Reset mid-QUAD (a=7, k=100)
        bus.start = 1'b1;
        bus.a     = 16'd7;
        bus.k     = 10'd100;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        check("midrst busy before", bus.busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst ready", bus.ready, 1);
        check("midrst busy",  bus.busy,  0);
        check("midrst c",     bus.c,     0);
        check("midrst done",  bus.done,  0);
        run_op(7, 10, "post rst");

        // rst beats start in the same cycle
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a     = 16'd11;
        bus.k     = 10'd0;
        step();
        rst       = 1'b0;
        bus.start = 1'b0;
        step();
        check("rst prio done", bus.done, 0);
        check("rst prio c",    bus.c,    0);
        check("rst prio idle", {bus.ready, bus.busy}, 2'b10);

        // Random pairs against the reference model
        for (int i = 0; i < 1000; i++) begin
            run_op(int'($urandom_range(65520, 0)), int'($urandom_range(40, 0)), "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
